// File: rtl/jb_aes_iter_core.sv
// Iterative XOR/byte-rotate block cipher core: one round per clock, round keys derived on the fly.
// Optional CBC chaining (iv/nIvLoad ports, chain register) is enabled by defining JB_AES_CBC_EN.
module jb_aes_iter_core #(
  parameter int unsigned BLOCK_WIDTH = 128,
  parameter int unsigned NUM_ROUNDS  = 10
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   nStart,
  input  logic                   decrypt,
  input  logic [BLOCK_WIDTH-1:0] key,
  input  logic [BLOCK_WIDTH-1:0] blockin,
`ifdef JB_AES_CBC_EN
  input  logic [BLOCK_WIDTH-1:0] iv,
  input  logic                   nIvLoad,
`endif
  output logic [BLOCK_WIDTH-1:0] blockout,
  output logic                   nDone,
  output logic                   busy
);

  localparam int unsigned NumBytes = BLOCK_WIDTH / 8;
  localparam logic [7:0]  LastRnd  = 8'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [BLOCK_WIDTH-1:0] s_q, s_d;
  logic [BLOCK_WIDTH-1:0] k_q, k_d;
  logic                   m_q, m_d;
  logic [BLOCK_WIDTH-1:0] blockout_q, blockout_d;
`ifdef JB_AES_CBC_EN
  logic [BLOCK_WIDTH-1:0] c_q, c_d;
  logic [BLOCK_WIDTH-1:0] b_q, b_d;
`endif

  logic [7:0]             rnd;
  int unsigned            sh;
  logic [BLOCK_WIDTH-1:0] rkey, t, res;

  // Decrypt walks the key schedule backwards so it exactly undoes encrypt.
  always_comb begin
    rnd  = m_q ? (LastRnd - cnt_q) : cnt_q;
    sh   = 8 * (32'(rnd) % NumBytes);
    rkey = ((k_q << sh) | (k_q >> (BLOCK_WIDTH - sh))) ^ BLOCK_WIDTH'(rnd);
    t    = s_q ^ rkey;
    if (m_q) res = {s_q[7:0], s_q[BLOCK_WIDTH-1:8]} ^ rkey;
    else     res = {t[BLOCK_WIDTH-9:0], t[BLOCK_WIDTH-1:BLOCK_WIDTH-8]};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s_d        = s_q;
    k_d        = k_q;
    m_d        = m_q;
    blockout_d = blockout_q;
`ifdef JB_AES_CBC_EN
    c_d        = c_q;
    b_d        = b_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef JB_AES_CBC_EN
        // IV load wins; a simultaneous start waits for the next sample.
        if (!nIvLoad) begin
          c_d = iv;
        end else if (!nStart) begin
          s_d     = decrypt ? blockin : (blockin ^ c_q);
          b_d     = blockin;
          k_d     = key;
          m_d     = decrypt;
          cnt_d   = '0;
          state_d = StRun;
        end
`else
        if (!nStart) begin
          s_d     = blockin;
          k_d     = key;
          m_d     = decrypt;
          cnt_d   = '0;
          state_d = StRun;
        end
`endif
      end
      StRun: begin
        s_d = res;
        if (cnt_q == LastRnd) begin
`ifdef JB_AES_CBC_EN
          blockout_d = m_q ? (res ^ c_q) : res;
          c_d        = m_q ? b_q : res;
`else
          blockout_d = res;
`endif
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      s_q        <= '0;
      k_q        <= '0;
      m_q        <= 1'b0;
      blockout_q <= '0;
`ifdef JB_AES_CBC_EN
      c_q        <= '0;
      b_q        <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      k_q        <= k_d;
      m_q        <= m_d;
      blockout_q <= blockout_d;
`ifdef JB_AES_CBC_EN
      c_q        <= c_d;
      b_q        <= b_d;
`endif
    end
  end

  assign blockout = blockout_q;
  assign nDone    = (state_q != StDone);
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_jb_aes_iter_core.sv
// Directed bench for jb_aes_iter_core: three instances (W16/R1, W16/R2, W128/R10) share stimulus.
// CBC vectors run only when JB_AES_CBC_EN is defined.
module tb_jb_aes_iter_core;

  logic         clk = 1'b0;
  logic         nRst, nStart, decrypt;
  logic [127:0] key, blockin;
  logic [15:0]  bo1, bo2;
  logic [127:0] bo3;
  logic         nd1, nd2, nd3, bz1, bz2, bz3;
`ifdef JB_AES_CBC_EN
  logic [127:0] iv;
  logic         nIvLoad;
`endif

  int errors = 0;
  int checks = 0;

  // Per-operation observations
  int           de1, de2, de3, dn1, dn2, dn3, bc3;
  logic [15:0]  r1, r2;
  logic [127:0] r3, ct;

  always #5 clk = ~clk;

  jb_aes_iter_core #(.BLOCK_WIDTH(16), .NUM_ROUNDS(1)) u_dut1 (
    .clk(clk), .nRst(nRst), .nStart(nStart), .decrypt(decrypt),
    .key(key[15:0]), .blockin(blockin[15:0]),
`ifdef JB_AES_CBC_EN
    .iv(iv[15:0]), .nIvLoad(nIvLoad),
`endif
    .blockout(bo1), .nDone(nd1), .busy(bz1)
  );

  jb_aes_iter_core #(.BLOCK_WIDTH(16), .NUM_ROUNDS(2)) u_dut2 (
    .clk(clk), .nRst(nRst), .nStart(nStart), .decrypt(decrypt),
    .key(key[15:0]), .blockin(blockin[15:0]),
`ifdef JB_AES_CBC_EN
    .iv(iv[15:0]), .nIvLoad(nIvLoad),
`endif
    .blockout(bo2), .nDone(nd2), .busy(bz2)
  );

  jb_aes_iter_core #(.BLOCK_WIDTH(128), .NUM_ROUNDS(10)) u_dut3 (
    .clk(clk), .nRst(nRst), .nStart(nStart), .decrypt(decrypt),
    .key(key), .blockin(blockin),
`ifdef JB_AES_CBC_EN
    .iv(iv), .nIvLoad(nIvLoad),
`endif
    .blockout(bo3), .nDone(nd3), .busy(bz3)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start one operation on all instances, scramble inputs after the start edge, then watch 13 edges.
  // pulse_at>0 drives nStart low for the edge following observation pulse_at.
  task automatic run_op(input logic dec, input logic [127:0] k, input logic [127:0] b,
                        input int pulse_at);
    @(negedge clk);
    decrypt = dec; key = k; blockin = b; nStart = 1'b0;
    @(posedge clk); #1;
    nStart = 1'b1; decrypt = ~dec; key = ~k; blockin = ~b;
    de1 = 0; de2 = 0; de3 = 0; dn1 = 0; dn2 = 0; dn3 = 0;
    bc3 = bz3 ? 1 : 0;
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk); #1;
      if (!nd1) begin dn1++; if (de1 == 0) begin de1 = e; r1 = bo1; end end
      if (!nd2) begin dn2++; if (de2 == 0) begin de2 = e; r2 = bo2; end end
      if (!nd3) begin dn3++; if (de3 == 0) begin de3 = e; r3 = bo3; end end
      if (bz3) bc3++;
      nStart = (e == pulse_at) ? 1'b0 : 1'b1;
    end
    nStart = 1'b1;
  endtask

  initial begin
    nRst = 1'b1; nStart = 1'b1; decrypt = 1'b0; key = '0; blockin = '0;
`ifdef JB_AES_CBC_EN
    iv = '0; nIvLoad = 1'b1;
`endif
    #3 nRst = 1'b0;
    #20;
    check_eq("rst_blockout", bo3, 128'h0);
    check_eq("rst_ndone", 128'(nd3), 128'h1);
    check_eq("rst_busy", 128'(bz3), 128'h0);
    @(negedge clk); nRst = 1'b1;

    // T1/T3 encrypt: R=1 gives CB12, R=2 gives 01FF
    run_op(1'b0, 128'h1234, 128'h00FF, 0);
    check_eq("t1_enc", 128'(r1), 128'hCB12);
    check_eq("t1_done_edge", 128'(de1), 128'd1);
    check_eq("t1_done_width", 128'(dn1), 128'd1);
    check_eq("t3_enc", 128'(r2), 128'h01FF);
    check_eq("t3_done_edge", 128'(de2), 128'd2);
    check_eq("t1_held", 128'(bo1), 128'hCB12);

    // T2 decrypt on R=1
    run_op(1'b1, 128'h1234, 128'hCB12, 0);
    check_eq("t2_dec", 128'(r1), 128'h00FF);

    // T3 decrypt on R=2
    run_op(1'b1, 128'h1234, 128'h01FF, 0);
    check_eq("t3_dec", 128'(r2), 128'h00FF);
    check_eq("t3_done_width", 128'(dn2), 128'd1);

    // T4 W=128 R=10 round trip with an nStart pulse during RUN
    run_op(1'b0, 128'h000102030405060708090a0b0c0d0e0f,
           128'h00112233445566778899aabbccddeeff, 2);
    ct = r3;
    check_eq("t4_enc_changed", 128'(ct != 128'h00112233445566778899aabbccddeeff), 128'h1);
    check_eq("t4_done_edge", 128'(de3), 128'd10);
    check_eq("t4_done_width", 128'(dn3), 128'd1);
    check_eq("t4_busy_cycles", 128'(bc3), 128'd11);
    check_eq("t4_r2_ignores_start_in_done", 128'(dn2), 128'd1);
    run_op(1'b1, 128'h000102030405060708090a0b0c0d0e0f, ct, 0);
    check_eq("t4_dec", r3, 128'h00112233445566778899aabbccddeeff);
    check_eq("t4_dec_edge", 128'(de3), 128'd10);
    repeat (2) @(posedge clk);
    #1 check_eq("t4_held", bo3, 128'h00112233445566778899aabbccddeeff);

    // T5 abort at cnt=5 with a start pulse mid-run
    @(negedge clk);
    decrypt = 1'b0; key = 128'h55; blockin = 128'hAA; nStart = 1'b0;
    @(posedge clk); #1 nStart = 1'b1;
    @(posedge clk); #1 nStart = 1'b0;
    @(posedge clk); #1 nStart = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_eq("t5_busy_before_abort", 128'(bz3), 128'h1);
    check_eq("t5_ndone_before_abort", 128'(nd3), 128'h1);
    nRst = 1'b0;
    #1;
    check_eq("t5_rst_blockout", bo3, 128'h0);
    check_eq("t5_rst_ndone", 128'(nd3), 128'h1);
    check_eq("t5_rst_busy", 128'(bz3), 128'h0);
    check_eq("t5_rst_blockout_r1", 128'(bo1), 128'h0);
    @(negedge clk); nRst = 1'b1;
    dn3 = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (!nd3 || bz3) dn3++;
    end
    check_eq("t5_no_done_after_abort", 128'(dn3), 128'd0);

`ifdef JB_AES_CBC_EN
    // T6 CBC: IV load beats a simultaneous start
    @(negedge clk);
    iv = 128'h0101; nIvLoad = 1'b0; nStart = 1'b0; key = 128'h1234; blockin = 128'h00FF;
    @(posedge clk); #1;
    check_eq("t6_start_deferred", 128'(bz1), 128'h0);
    nIvLoad = 1'b1; nStart = 1'b1;
    run_op(1'b0, 128'h1234, 128'h00FF, 0);
    check_eq("t6_enc1", 128'(r1), 128'hCA13);
    run_op(1'b0, 128'h1234, 128'h00FF, 0);
    check_eq("t6_enc2", 128'(r1), 128'hD8D8);
    @(negedge clk);
    iv = 128'hCA13; nIvLoad = 1'b0;
    @(negedge clk); nIvLoad = 1'b1;
    run_op(1'b1, 128'h1234, 128'hD8D8, 0);
    check_eq("t6_dec", 128'(r1), 128'h00FF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
